// File: rtl/vid_word_packer.sv
// Packs video elementary-stream bytes into 32-bit vbuf words, tagging MPEG
// start-code prefixes (00 00 01) and flushing a final partial word at end of stream.
module vid_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [7:0]  vid_in,
    input  logic        vid_empty,
    output logic        vid_rd,
    input  logic        vid_end_in,
    input  logic        vbuf_afull,
    output logic [31:0] vbuf_out,
    output logic [3:0]  vbuf_sc,
    output logic [2:0]  vbuf_nbytes,
    output logic        vbuf_last,
    output logic        vbuf_wr
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_FLUSH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        byte_valid_q, byte_valid_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  sc_acc_q, sc_acc_d;
    logic [23:0] history_q, history_d;
    logic [31:0] vbuf_out_q, vbuf_out_d;
    logic [3:0]  vbuf_sc_q, vbuf_sc_d;
    logic [2:0]  vbuf_nbytes_q, vbuf_nbytes_d;
    logic        vbuf_last_q, vbuf_last_d;
    logic        wr_en_q, wr_en_d;
    logic        is_sc;

    assign vid_rd      = clk_en && (state_q == S_FILL) && ~vbuf_afull;
    assign vbuf_wr     = wr_en_q && clk_en;
    assign vbuf_out    = vbuf_out_q;
    assign vbuf_sc     = vbuf_sc_q;
    assign vbuf_nbytes = vbuf_nbytes_q;
    assign vbuf_last   = vbuf_last_q;

    // History spans word boundaries, so a prefix split across words is still found.
    assign is_sc = (vid_in == 8'h01) && (history_q[15:0] == 16'h0000);

    always_comb begin
        state_d       = state_q;
        byte_valid_d  = byte_valid_q;
        byte_idx_d    = byte_idx_q;
        word_d        = word_q;
        sc_acc_d      = sc_acc_q;
        history_d     = history_q;
        vbuf_out_d    = vbuf_out_q;
        vbuf_sc_d     = vbuf_sc_q;
        vbuf_nbytes_d = vbuf_nbytes_q;
        vbuf_last_d   = vbuf_last_q;
        wr_en_d       = wr_en_q;

        if (clk_en) begin
            wr_en_d      = 1'b0;
            byte_valid_d = vid_rd && ~vid_empty;
            case (state_q)
                S_FILL: begin
                    if (byte_valid_q) begin
                        history_d  = {history_q[15:0], vid_in};
                        byte_idx_d = byte_idx_q + 2'd1;
                        word_d[{~byte_idx_q, 3'b000} +: 8] = vid_in;
                        sc_acc_d[~byte_idx_q]              = is_sc;
                        // Accumulator is cleared on a full word so a later flush pads with zeros.
                        if (byte_idx_q == 2'd3) begin
                            vbuf_out_d    = {word_q[31:8], vid_in};
                            vbuf_sc_d     = {sc_acc_q[3:1], is_sc};
                            vbuf_nbytes_d = 3'd4;
                            vbuf_last_d   = 1'b0;
                            wr_en_d       = 1'b1;
                            word_d        = 32'h0;
                            sc_acc_d      = 4'h0;
                        end
                    end else if (vid_end_in && vid_empty) begin
                        state_d = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (~vbuf_afull) begin
                        vbuf_out_d    = word_q;
                        vbuf_sc_d     = sc_acc_q;
                        vbuf_nbytes_d = {1'b0, byte_idx_q};
                        vbuf_last_d   = 1'b1;
                        wr_en_d       = 1'b1;
                        state_d       = S_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_FILL;
            byte_valid_q  <= 1'b0;
            byte_idx_q    <= 2'd0;
            word_q        <= 32'h0;
            sc_acc_q      <= 4'h0;
            history_q     <= 24'hFFFFFF;
            vbuf_out_q    <= 32'h0;
            vbuf_sc_q     <= 4'h0;
            vbuf_nbytes_q <= 3'd0;
            vbuf_last_q   <= 1'b0;
            wr_en_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_valid_q  <= byte_valid_d;
            byte_idx_q    <= byte_idx_d;
            word_q        <= word_d;
            sc_acc_q      <= sc_acc_d;
            history_q     <= history_d;
            vbuf_out_q    <= vbuf_out_d;
            vbuf_sc_q     <= vbuf_sc_d;
            vbuf_nbytes_q <= vbuf_nbytes_d;
            vbuf_last_q   <= vbuf_last_d;
            wr_en_q       <= wr_en_d;
        end
    end

endmodule

// File: tb/tb_vid_word_packer.sv
// Self-checking bench for vid_word_packer: a queue-based FIFO model feeds bytes,
// written words are collected and compared against a stream-level reference.
module tb_vid_word_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b0;
    logic [7:0]  vid_in = 8'h00;
    logic        vid_empty = 1'b1;
    logic        vid_rd;
    logic        vid_end_in = 1'b0;
    logic        vbuf_afull = 1'b0;
    logic [31:0] vbuf_out;
    logic [3:0]  vbuf_sc;
    logic [2:0]  vbuf_nbytes;
    logic        vbuf_last;
    logic        vbuf_wr;

    vid_word_packer dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .vid_in(vid_in), .vid_empty(vid_empty), .vid_rd(vid_rd),
        .vid_end_in(vid_end_in), .vbuf_afull(vbuf_afull),
        .vbuf_out(vbuf_out), .vbuf_sc(vbuf_sc), .vbuf_nbytes(vbuf_nbytes),
        .vbuf_last(vbuf_last), .vbuf_wr(vbuf_wr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int stall_lo = -1, stall_hi = -1;
    int p_gap = 0, p_clken_low = 0, p_afull = 0;
    bit end_pending = 1'b0;

    logic [7:0]  fifo[$];
    logic [7:0]  src[$];
    logic [39:0] obs[$];
    logic [39:0] exp_q[$];
    int          obs_cyc[$];
    int          pop_cyc[$];

    function automatic bit is_sc(input logic [7:0] b[$], input int i);
        if (i < 2) return 1'b0;
        return (b[i] == 8'h01) && (b[i-1] == 8'h00) && (b[i-2] == 8'h00);
    endfunction

    // Reference: chop the stream into 4-byte words, pad the tail, mark prefixes over the whole stream.
    task automatic build_expected(input logic [7:0] b[$], input bit with_end);
        int n;
        logic [31:0] w;
        logic [3:0]  s;
        n = b.size();
        exp_q.delete();
        for (int k = 0; k + 4 <= n; k += 4) begin
            w = 32'h0;
            s = 4'h0;
            for (int j = 0; j < 4; j++) begin
                w = {w[23:0], b[k+j]};
                s = {s[2:0], is_sc(b, k + j)};
            end
            exp_q.push_back({1'b0, 3'd4, s, w});
        end
        if (with_end) begin
            w = 32'h0;
            s = 4'h0;
            for (int j = 0; j < 4; j++) begin
                if ((n / 4) * 4 + j < n) begin
                    w = {w[23:0], b[(n / 4) * 4 + j]};
                    s = {s[2:0], is_sc(b, (n / 4) * 4 + j)};
                end else begin
                    w = {w[23:0], 8'h00};
                    s = {s[2:0], 1'b0};
                end
            end
            exp_q.push_back({1'b1, 3'(n % 4), s, w});
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, observe, then update the FIFO output.
    task automatic step();
        bit pop;
        clk_en     = ($urandom_range(99) >= p_clken_low);
        vbuf_afull = (cycle >= stall_lo && cycle < stall_hi) || ($urandom_range(99) < p_afull);
        if (src.size() > 0 && $urandom_range(99) >= p_gap) fifo.push_back(src.pop_front());
        vid_end_in = end_pending && (src.size() == 0);
        vid_empty  = (fifo.size() == 0);
        #1;
        if (!clk_en || vbuf_afull) begin
            total++;
            if (vid_rd !== 1'b0) begin
                bad++;
                $display("FAIL rd_gated cycle=%0d: vid_rd=%b want 0", cycle, vid_rd);
            end
        end
        if (!clk_en) begin
            total++;
            if (vbuf_wr !== 1'b0) begin
                bad++;
                $display("FAIL wr_gated cycle=%0d: vbuf_wr=%b want 0", cycle, vbuf_wr);
            end
        end
        if (vbuf_wr === 1'b1) begin
            obs.push_back({vbuf_last, vbuf_nbytes, vbuf_sc, vbuf_out});
            obs_cyc.push_back(cycle);
        end
        pop = (vid_rd === 1'b1) && !vid_empty;
        if (pop) pop_cyc.push_back(cycle);
        @(posedge clk);
        #1;
        if (pop) vid_in = fifo.pop_front();
        cycle++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fifo.delete(); src.delete(); obs.delete(); obs_cyc.delete(); pop_cyc.delete();
        vid_empty = 1'b1; vid_end_in = 1'b0; end_pending = 1'b0;
        clk_en = 1'b1; vbuf_afull = 1'b0;
        stall_lo = -1; stall_hi = -1; p_gap = 0; p_clken_low = 0; p_afull = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycle = 0;
    endtask

    task automatic run_stream(input logic [7:0] b[$], input bit with_end, input int ncycles);
        src = b;
        end_pending = with_end;
        build_expected(b, with_end);
        for (int i = 0; i < ncycles; i++) step();
    endtask

    task automatic test_reset();
        #3;
        rst = 1'b0;
        clk_en = 1'b1;
        vbuf_afull = 1'b0;
        #1;
        total++;
        if ({vbuf_out, vbuf_sc, vbuf_nbytes, vbuf_last, vbuf_wr} !== 41'h0) begin
            bad++;
            $display("FAIL reset_outputs: got out=%h sc=%b nb=%0d last=%b wr=%b want all 0",
                     vbuf_out, vbuf_sc, vbuf_nbytes, vbuf_last, vbuf_wr);
        end
        total++;
        if (vid_rd !== 1'b1) begin
            bad++;
            $display("FAIL reset_rd_en: vid_rd=%b want 1", vid_rd);
        end
        clk_en = 1'b0;
        #1;
        total++;
        if (vid_rd !== 1'b0) begin
            bad++;
            $display("FAIL reset_rd_clken: vid_rd=%b want 0", vid_rd);
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [7:0] b[$];
        do_reset();
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(b, 1'b0, 20);
        total++;
        if (obs.size() !== 1) begin
            bad++;
            $display("FAIL basic_count: got %0d words want 1", obs.size());
        end else begin
            total++;
            if (obs[0] !== {1'b0, 3'd4, 4'b0000, 32'h11223344}) begin
                bad++;
                $display("FAIL basic_word: got %h want %h", obs[0], {1'b0, 3'd4, 4'b0000, 32'h11223344});
            end
            total++;
            if (pop_cyc.size() < 4 || obs_cyc[0] !== pop_cyc[3] + 2) begin
                bad++;
                $display("FAIL basic_latency: write cycle %0d, reads %0d want 4th read + 2",
                         obs_cyc[0], pop_cyc.size());
            end
        end
    endtask

    task automatic test_start_codes();
        logic [7:0] b[$];
        logic [3:0] want_sc[2];
        want_sc[0] = 4'b0010;
        want_sc[1] = 4'b0001;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            if (t == 0) b = '{8'h00, 8'h00, 8'h01, 8'hB3};
            else        b = '{8'hAA, 8'h00, 8'h00, 8'h01};
            run_stream(b, 1'b0, 20);
            total++;
            if (obs.size() !== 1) begin
                bad++;
                $display("FAIL sc_count%0d: got %0d words want 1", t, obs.size());
            end else begin
                total++;
                if (obs[0] !== exp_q[0] || obs[0][35:32] !== want_sc[t]) begin
                    bad++;
                    $display("FAIL sc_word%0d: got %h want %h", t, obs[0], exp_q[0]);
                end
            end
        end
    endtask

    task automatic test_cross_boundary();
        logic [7:0] b[$];
        do_reset();
        b = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h01, 8'hB3, 8'h00, 8'h00, 8'h01, 8'hB5, 8'h00, 8'h00};
        run_stream(b, 1'b0, 30);
        total++;
        if (obs.size() !== 3) begin
            bad++;
            $display("FAIL cross_count: got %0d words want 3", obs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL cross_word%0d: got %h want %h", i, obs[i], exp_q[i]);
                end
            end
            total++;
            if (obs[1][35:32] !== 4'b1000 || obs[2][35:32] !== 4'b1000) begin
                bad++;
                $display("FAIL cross_sc: got %b %b want 1000 1000", obs[1][35:32], obs[2][35:32]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b[$];
        do_reset();
        for (int i = 0; i < 16; i++) b.push_back(8'(i * 17 + 3));
        b[5] = 8'h00; b[6] = 8'h00; b[7] = 8'h01;
        stall_lo = 6;
        stall_hi = 16;
        run_stream(b, 1'b0, 50);
        total++;
        if (obs.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL stall_count: got %0d words want %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs.size()) begin
                total++;
                if (obs[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL stall_word%0d: got %h want %h", i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [7:0] b[$];
        for (int t = 0; t < 2; t++) begin
            do_reset();
            if (t == 0) b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
            else        b = '{8'h11, 8'h22, 8'h33, 8'h44};
            run_stream(b, 1'b1, 30);
            total++;
            if (obs.size() !== 2) begin
                bad++;
                $display("FAIL flush_count%0d: got %0d words want 2", t, obs.size());
            end else begin
                for (int i = 0; i < 2; i++) begin
                    total++;
                    if (obs[i] !== exp_q[i]) begin
                        bad++;
                        $display("FAIL flush%0d_word%0d: got %h want %h", t, i, obs[i], exp_q[i]);
                    end
                end
            end
            for (int i = 0; i < 8; i++) begin
                fifo.push_back(8'hEE);
                step();
            end
            total++;
            if (obs.size() !== 2 || fifo.size() !== 8) begin
                bad++;
                $display("FAIL done_idle%0d: got %0d words %0d bytes left want 2 words 8 left",
                         t, obs.size(), fifo.size());
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] b[$];
        do_reset();
        b = '{8'hC1, 8'hC2};
        run_stream(b, 1'b0, 6);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({vbuf_out, vbuf_sc, vbuf_nbytes, vbuf_last, vbuf_wr} !== 41'h0) begin
            bad++;
            $display("FAIL async_reset: got out=%h sc=%b nb=%0d last=%b wr=%b want all 0",
                     vbuf_out, vbuf_sc, vbuf_nbytes, vbuf_last, vbuf_wr);
        end
        @(negedge clk);
        do_reset();
        b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_stream(b, 1'b0, 20);
        total++;
        if (obs.size() !== 1 || obs[0] !== {1'b0, 3'd4, 4'b0000, 32'hA1B2C3D4}) begin
            bad++;
            $display("FAIL async_newword: got %0d words first %h want 1 word %h",
                     obs.size(), (obs.size() > 0) ? obs[0] : 40'h0, {1'b0, 3'd4, 4'b0000, 32'hA1B2C3D4});
        end
    endtask

    task automatic test_random();
        logic [7:0] b[$];
        bit with_end;
        int n;
        for (int it = 0; it < 10; it++) begin
            do_reset();
            p_gap = 20;
            p_clken_low = 20;
            p_afull = 15;
            n = $urandom_range(23);
            with_end = (it % 3 != 2);
            b.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(3))
                    0, 1:    b.push_back(8'h00);
                    2:       b.push_back(8'h01);
                    default: b.push_back(8'($urandom));
                endcase
            end
            run_stream(b, with_end, 400);
            total++;
            if (obs.size() !== exp_q.size()) begin
                bad++;
                $display("FAIL rand%0d_count: got %0d words want %0d (n=%0d end=%0d)",
                         it, obs.size(), exp_q.size(), n, with_end);
            end
            foreach (exp_q[i]) begin
                if (i < obs.size()) begin
                    total++;
                    if (obs[i] !== exp_q[i]) begin
                        bad++;
                        $display("FAIL rand%0d_word%0d: got %h want %h", it, i, obs[i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_codes();
        test_cross_boundary();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
